// File: rtl/alu_operand_issue.sv
// Decode/operand-fetch stage feeding the 16-bit ALU: 8x16 register file, pending
// scoreboard, one-entry issue register. Define ALU_ISSUE_FWD_EN to bypass writeback data.
module alu_operand_issue #(
    parameter int              DW      = 16,
    parameter int              NREG    = 8,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_opcode,
    output logic [DW-1:0] out_rsval,
    output logic [DW-1:0] out_rtval,
    output logic [2:0]    out_shamt,
    output logic [2:0]    out_rd,
    input  logic          wb_en,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          illegal
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_pending;

    logic            r_out_valid;
    logic [3:0]      r_out_opcode;
    logic [DW-1:0]   r_out_rsval;
    logic [DW-1:0]   r_out_rtval;
    logic [2:0]      r_out_shamt;
    logic [2:0]      r_out_rd;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic [2:0]      w_rs;
    logic [2:0]      w_rt;
    logic [2:0]      w_rd;
    logic [2:0]      w_shamt;
    logic            w_legal;
    logic            w_use_rs;
    logic            w_use_rt;
    logic            w_rs_byp;
    logic            w_rt_byp;
    logic            w_haz_rs;
    logic            w_haz_rt;
    logic            w_hazard;
    logic [DW-1:0]   w_rs_val;
    logic [DW-1:0]   w_rt_val;
    logic            w_accept;
    logic            w_wb_write;

    assign w_op    = in_instr[15:12];
    assign w_rs    = in_instr[11:9];
    assign w_rt    = in_instr[8:6];
    assign w_rd    = in_instr[5:3];
    assign w_shamt = in_instr[2:0];

    always_comb begin
        w_legal  = 1'b0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        case (w_op)
            4'd0, 4'd3, 4'd4, 4'd6, 4'd7: begin
                w_legal  = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            4'd1, 4'd2: begin
                w_legal  = 1'b1;
                w_use_rs = 1'b1;
            end
            4'd11, 4'd12: begin
                w_legal  = 1'b1;
            end
            default: begin
                w_legal  = 1'b0;
            end
        endcase
    end

    assign w_wb_write = wb_en && (wb_addr != 3'd0);

`ifdef ALU_ISSUE_FWD_EN
    assign w_rs_byp = w_wb_write && (wb_addr == w_rs);
    assign w_rt_byp = w_wb_write && (wb_addr == w_rt);
`else
    assign w_rs_byp = 1'b0;
    assign w_rt_byp = 1'b0;
`endif

    // r0 is never marked pending, so no explicit r0 exclusion is needed here.
    assign w_haz_rs = w_use_rs && r_pending[w_rs] && !w_rs_byp;
    assign w_haz_rt = w_use_rt && r_pending[w_rt] && !w_rt_byp;
    assign w_hazard = w_haz_rs || w_haz_rt;

    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_use_rs && (w_rs != 3'd0)) begin
            w_rs_val = w_rs_byp ? wb_data : r_regs[w_rs];
        end
        if (w_use_rt && (w_rt != 3'd0)) begin
            w_rt_val = w_rt_byp ? wb_data : r_regs[w_rt];
        end
    end

    // Illegal opcodes are swallowed without a hazard check since they never issue.
    assign in_ready = (!r_out_valid || out_ready) && (!w_legal || !w_hazard);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= RST_VAL;
            end
            r_pending <= '0;
        end else begin
            if (w_wb_write) begin
                r_regs[wb_addr]    <= wb_data;
                r_pending[wb_addr] <= 1'b0;
            end
            // Later assignment wins: a new issue re-claims a register being written back.
            if (w_accept && w_legal && (w_rd != 3'd0)) begin
                r_pending[w_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_opcode <= '0;
            r_out_rsval  <= '0;
            r_out_rtval  <= '0;
            r_out_shamt  <= '0;
            r_out_rd     <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_out_valid  <= 1'b1;
                r_out_opcode <= w_op;
                r_out_rsval  <= w_rs_val;
                r_out_rtval  <= w_rt_val;
                r_out_shamt  <= w_shamt;
                r_out_rd     <= w_rd;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_opcode = r_out_opcode;
    assign out_rsval  = r_out_rsval;
    assign out_rtval  = r_out_rtval;
    assign out_shamt  = r_out_shamt;
    assign out_rd     = r_out_rd;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios then random traffic against a
// behavioural model (register array, pending set, expected issue queue).
module tb_alu_operand_issue;

    localparam int DW = 16;
`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [15:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_opcode;
    logic [DW-1:0] out_rsval;
    logic [DW-1:0] out_rtval;
    logic [2:0]    out_shamt;
    logic [2:0]    out_rd;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          illegal;

    always #5 clk = ~clk;

    alu_operand_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rsval  (out_rsval),
        .out_rtval  (out_rtval),
        .out_shamt  (out_shamt),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal    (illegal)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [41:0] exp_q[$];
    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;
    logic        m_ill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rs, input int rt, input int rd, input int sh);
        return {op[3:0], rs[2:0], rt[2:0], rd[2:0], sh[2:0]};
    endfunction

    function automatic void op_class(input logic [3:0] op, output bit legal, output bit use_rs, output bit use_rt);
        legal = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (op inside {4'd0, 4'd3, 4'd4, 4'd6, 4'd7}) begin
            legal = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        end else if (op inside {4'd1, 4'd2}) begin
            legal = 1'b1; use_rs = 1'b1;
        end else if (op inside {4'd11, 4'd12}) begin
            legal = 1'b1;
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_pend = 8'h00;
        m_ill = 1'b0;
    endtask

    function automatic logic [15:0] operand(input bit used, input logic [2:0] a, input bit we,
                                            input logic [2:0] wa, input logic [15:0] wd);
        if (!used || a == 3'd0) return 16'h0000;
        if (FWD && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    // Drives one cycle starting 1 time unit after a rising edge; samples 3 units later.
    task automatic cycle(input bit v, input logic [15:0] instr, input bit ordy,
                         input bit we, input logic [2:0] wa, input logic [15:0] wd);
        bit legal, urs, urt, ov, haz, ready, acc;
        logic [2:0] rs, rt, rd;
        logic [15:0] rsv, rtv;
        in_valid = v; in_instr = instr; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #3;
        rs = instr[11:9]; rt = instr[8:6]; rd = instr[5:3];
        op_class(instr[15:12], legal, urs, urt);
        ov = (exp_q.size() != 0);
        haz = (urs && rs != 3'd0 && m_pend[rs] && !(FWD && we && wa == rs)) ||
              (urt && rt != 3'd0 && m_pend[rt] && !(FWD && we && wa == rt));
        ready = (!ov || ordy) && (!legal || !haz);
        check("in_ready", {63'd0, in_ready}, {63'd0, ready});
        check("out_valid", {63'd0, out_valid}, {63'd0, ov});
        check("illegal", {63'd0, illegal}, {63'd0, m_ill});
        if (ov) check("issue_fields", {out_opcode, out_rsval, out_rtval, out_shamt, out_rd}, exp_q[0]);
        rsv = operand(urs, rs, we, wa, wd);
        rtv = operand(urt, rt, we, wa, wd);
        acc = v && ready;
        if (ov && ordy) void'(exp_q.pop_front());
        m_ill = acc && !legal;
        if (acc && legal) exp_q.push_back({instr[15:12], rsv, rtv, instr[2:0], rd});
        if (we && wa != 3'd0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
        end
        if (acc && legal && rd != 3'd0) m_pend[rd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 16'h0000, ordy, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic wb(input logic [2:0] wa, input logic [15:0] wd);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1, wa, wd);
    endtask

    logic [15:0] dep;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        model_reset();
        @(posedge clk); #1;
        check("reset_outputs", {out_valid, out_opcode, out_rsval, out_rtval, out_shamt, out_rd, illegal}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic add after writing r1/r2
        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        cycle(1'b1, enc(0, 1, 2, 1, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        check("first_issue", {out_valid, out_opcode, out_rsval, out_rtval, out_rd},
              {1'b1, 4'd0, 16'd5, 16'd3, 3'd1});
        cycle(1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0008);

        // Dependent pair through r3, writeback withheld for 4 cycles
        cycle(1'b1, enc(0, 1, 2, 3, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        dep = enc(0, 3, 2, 4, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, dep, 1'b1, 1'b0, 3'd0, 16'h0);
        cycle(1'b1, dep, 1'b1, 1'b1, 3'd3, 16'h1234);
        cycle(FWD ? 1'b0 : 1'b1, dep, 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);
        wb(3'd4, 16'h00aa);

        // Back-pressure: held output, then resume without a bubble
        cycle(1'b1, enc(6, 1, 2, 5, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, enc(7, 1, 2, 6, 0), 1'b0, 1'b0, 3'd0, 16'h0);
        cycle(1'b1, enc(7, 1, 2, 6, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);
        idle(1'b1);
        wb(3'd5, 16'h0001);
        wb(3'd6, 16'h0002);

        // Unsupported opcode 5
        cycle(1'b1, enc(5, 3, 3, 3, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);
        idle(1'b1);

        // shl stalls on rs only; rt pending is irrelevant
        cycle(1'b1, enc(0, 0, 0, 1, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 2; i++) cycle(1'b1, enc(1, 1, 1, 2, 3), 1'b1, 1'b0, 3'd0, 16'h0);
        cycle(1'b1, enc(1, 2, 1, 7, 3), 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);
        // Everything pending, mfhi still issues
        for (int k = 1; k < 8; k++) cycle(1'b1, enc(0, 0, 0, k, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        cycle(1'b1, enc(12, 1, 2, 5, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);
        for (int k = 1; k < 8; k++) wb(k[2:0], 16'h0100 + k[15:0]);

        // Async reset during a stall with r3 pending and output held
        cycle(1'b1, enc(0, 0, 0, 3, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        cycle(1'b1, enc(0, 3, 3, 1, 0), 1'b0, 1'b0, 3'd0, 16'h0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_fields", {out_opcode, out_rsval, out_rtval, out_shamt, out_rd}, 64'd0);
        check("async_rst_pending", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b1, enc(0, 1, 2, 1, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        check("post_rst_regs", {out_valid, out_rsval, out_rtval}, {1'b1, 16'h0000, 16'h0000});
        // Writes to r0 are dropped
        cycle(1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 16'hffff);
        wb(3'd1, 16'h0042);
        cycle(1'b1, enc(3, 0, 1, 2, 0), 1'b1, 1'b0, 3'd0, 16'h0);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0,
                  3'($urandom_range(0, 7)),
                  16'($urandom));
        end
        for (int n = 0; n < 3; n++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
